// File: rtl/mlp_layer_seq_if.sv
// Handshake, coefficient-write and result bundle of one mlp_layer_seq layer.
// slave is the layer's view; master is the view of the upstream/downstream driver.
interface mlp_layer_seq_if #(
  parameter int DATA_W  = 20,
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 3,
  parameter int ADDR_W  = $clog2(NUM_OUT*(NUM_IN+1))
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_IN*DATA_W-1:0]    in_data;
  logic [1:0]                  act_mode;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_OUT*DATA_W-1:0]   out_data;
  logic [NUM_OUT-1:0]          out_class;

  modport slave (
    input  in_valid, in_data, act_mode, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, out_data, out_class
  );

  modport master (
    output in_valid, in_data, act_mode, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, out_data, out_class
  );
endinterface

// File: rtl/mlp_layer_seq.sv
// Time-multiplexed FC layer, one MAC per cycle; result valid NUM_OUT*(NUM_IN+1) cycles after accept.
// One vector in flight: in_ready only in IDLE, results held in DONE until out_ready.
module mlp_layer_seq #(
  parameter int DATA_W  = 20,
  parameter int FRAC_W  = 16,
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 3,
  parameter int ADDR_W  = $clog2(NUM_OUT*(NUM_IN+1))
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mlp_layer_seq_if.slave io_bus
);
  localparam int NUM_COEF = NUM_OUT*(NUM_IN+1);
  localparam int ACC_W    = 2*DATA_W + $clog2(NUM_IN+1);
  localparam int I_W      = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int J_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [I_W-1:0]    LAST_I     = I_W'(NUM_IN-1);
  localparam logic [J_W-1:0]    LAST_J     = J_W'(NUM_OUT-1);
  localparam logic [ADDR_W-1:0] BIAS0_ADDR = ADDR_W'(NUM_IN);

  localparam logic signed [ACC_W-1:0]  ROUND_HALF = ACC_W'(1) <<< (FRAC_W-1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN    = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] OUT_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] STEP_ONE   = DATA_W'(1) << FRAC_W;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                      r_state;
  logic [NUM_COEF*DATA_W-1:0]  r_coef;
  logic [NUM_IN*DATA_W-1:0]    r_x;
  logic [1:0]                  r_mode;
  logic [I_W-1:0]              r_i;
  logic [J_W-1:0]              r_j;
  logic [ADDR_W-1:0]           r_addr;
  logic signed [ACC_W-1:0]     r_acc;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic [NUM_OUT*DATA_W-1:0]   r_out_data;
  logic [NUM_OUT-1:0]          r_out_class;

  logic                        w_accept;
  logic                        w_wr_ok;
  logic signed [DATA_W-1:0]    w_bias0;
  logic signed [DATA_W-1:0]    w_next_bias;
  logic signed [DATA_W-1:0]    w_x;
  logic signed [DATA_W-1:0]    w_w;
  logic signed [2*DATA_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]     w_rnd;
  logic signed [DATA_W-1:0]    w_sat;
  logic signed [DATA_W-1:0]    w_act;
  logic                        w_class;
  int                          w_nb_idx;

  function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic signed [DATA_W-1:0] b);
    return {{(ACC_W-DATA_W){b[DATA_W-1]}}, b} <<< FRAC_W;
  endfunction

  assign w_accept = r_in_ready && io_bus.in_valid;
  assign w_wr_ok  = (r_state == S_IDLE) && io_bus.wr_en && (int'(io_bus.wr_addr) < NUM_COEF);

  // A bias-0 write in the accept cycle must already seed this vector's accumulator.
  assign w_bias0 = (w_wr_ok && (io_bus.wr_addr == BIAS0_ADDR)) ? io_bus.wr_data
                                                               : r_coef[NUM_IN*DATA_W +: DATA_W];

  assign w_x    = r_x[int'(r_i)*DATA_W +: DATA_W];
  assign w_w    = r_coef[int'(r_addr)*DATA_W +: DATA_W];
  assign w_prod = {{DATA_W{w_x[DATA_W-1]}}, w_x} * {{DATA_W{w_w[DATA_W-1]}}, w_w};

  always_comb begin
    w_nb_idx = 0;
    if (r_j != LAST_J) begin
      w_nb_idx = int'(r_addr) + NUM_IN + 1;
    end
    w_next_bias = r_coef[w_nb_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    w_rnd = (r_acc + ROUND_HALF) >>> FRAC_W;
    w_sat = w_rnd[DATA_W-1:0];
    if (w_rnd > SAT_MAX) begin
      w_sat = OUT_MAX;
    end else if (w_rnd < SAT_MIN) begin
      w_sat = OUT_MIN;
    end
    w_class = ~w_sat[DATA_W-1];
    case (r_mode)
      2'd1:    w_act = w_class ? w_sat    : '0;
      2'd2:    w_act = w_class ? STEP_ONE : '0;
      default: w_act = w_sat;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_coef      <= '0;
      r_x         <= '0;
      r_mode      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_addr      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_class <= '0;
    end else begin
      if (w_wr_ok) begin
        r_coef[int'(io_bus.wr_addr)*DATA_W +: DATA_W] <= io_bus.wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x        <= io_bus.in_data;
            r_mode     <= io_bus.act_mode;
            r_i        <= '0;
            r_j        <= '0;
            r_addr     <= '0;
            r_acc      <= bias_to_acc(w_bias0);
            r_in_ready <= 1'b0;
            r_state    <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc  <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
          r_addr <= r_addr + ADDR_W'(1);
          if (r_i == LAST_I) begin
            r_i     <= '0;
            r_state <= S_WRITE;
          end else begin
            r_i <= r_i + I_W'(1);
          end
        end
        S_WRITE: begin
          r_out_data[int'(r_j)*DATA_W +: DATA_W] <= w_act;
          r_out_class[r_j]                       <= w_class;
          if (r_j == LAST_J) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            // r_addr sits on neuron j's bias; step past it to neuron j+1's first weight.
            r_j     <= r_j + J_W'(1);
            r_addr  <= r_addr + ADDR_W'(1);
            r_acc   <= bias_to_acc(w_next_bias);
            r_state <= S_MAC;
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_class = r_out_class;
endmodule

// File: tb/tb_mlp_layer_seq.sv
// Directed bench for mlp_layer_seq: vector table plus hand sequences for
// backpressure, write gating and mid-computation reset.
module tb_mlp_layer_seq;
  localparam int DW = 20;
  localparam int NI = 3;
  localparam int NO = 3;
  localparam int NC = NO*(NI+1);
  localparam int AW = 4;

  localparam logic [DW-1:0] Z    = 20'h00000;
  localparam logic [DW-1:0] ONE  = 20'h10000;
  localparam logic [DW-1:0] M8   = 20'h80000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mlp_layer_seq_if #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .ADDR_W(AW)) bus ();

  mlp_layer_seq #(.DATA_W(DW), .FRAC_W(16), .NUM_IN(NI), .NUM_OUT(NO), .ADDR_W(AW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic [NC*DW-1:0] coef;
    logic [NI*DW-1:0] x;
    logic [1:0]       mode;
    logic [NO*DW-1:0] exp_d;
    logic [NO-1:0]    exp_c;
    string            name;
  } vec_t;

  vec_t vt[9];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [NC*DW-1:0] cl_coef, rp_coef, rn_coef, ns_coef, bn_coef;
  logic [NI*DW-1:0] x1, xr, x7;

  function automatic logic [4*DW-1:0] nr(input logic [DW-1:0] w0, w1, w2, b);
    return {b, w2, w1, w0};
  endfunction

  function automatic logic [NC*DW-1:0] cf(input logic [4*DW-1:0] n0, n1, n2);
    return {n2, n1, n0};
  endfunction

  function automatic logic [3*DW-1:0] v3(input logic [DW-1:0] a, b, c);
    return {c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NC*DW-1:0] c);
    for (int k = 0; k < NC; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(k);
      bus.wr_data = c[k*DW +: DW];
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic start(input logic [NI*DW-1:0] x, input logic [1:0] m);
    bus.in_data  = x;
    bus.act_mode = m;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid; -1 if it never rises.
  task automatic wait_valid(input bit mac_wr, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (mac_wr && c == 2) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd3;
        bus.wr_data = ONE;
      end
      tick();
      bus.wr_en = 1'b0;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [NO*DW-1:0] held;

    cl_coef = cf(nr(ONE, ONE, ONE, Z), nr(20'hF0000, Z, Z, 20'h04000), nr(20'h70000, Z, 20'h70000, Z));
    rp_coef = cf(nr(20'h08000, Z, Z, Z), nr(Z, Z, Z, Z), nr(Z, Z, Z, Z));
    rn_coef = cf(nr(20'hF8000, Z, Z, Z), nr(Z, Z, Z, Z), nr(Z, Z, Z, Z));
    ns_coef = cf(nr(M8, M8, M8, Z), nr(M8, M8, M8, Z), nr(M8, M8, M8, Z));
    bn_coef = cf(nr(Z, Z, Z, 20'hFFFFF), nr(Z, Z, Z, Z), nr(Z, Z, Z, Z));
    x1 = v3(ONE, Z, 20'h08000);
    xr = v3(20'h00001, Z, Z);
    x7 = v3(20'h70000, 20'h70000, 20'h70000);

    vt[0] = '{cl_coef, x1, 2'd1, v3(20'h18000, Z, 20'h7FFFF),       3'b101, "classify_relu"};
    vt[1] = '{cl_coef, x1, 2'd0, v3(20'h18000, 20'hF4000, 20'h7FFFF), 3'b101, "classify_linear"};
    vt[2] = '{cl_coef, x1, 2'd2, v3(ONE, Z, ONE),                    3'b101, "classify_step"};
    vt[3] = '{cl_coef, x1, 2'd3, v3(20'h18000, 20'hF4000, 20'h7FFFF), 3'b101, "classify_mode3"};
    vt[4] = '{rp_coef, xr, 2'd0, v3(20'h00001, Z, Z),                3'b111, "round_half_up"};
    vt[5] = '{rn_coef, xr, 2'd0, v3(Z, Z, Z),                        3'b111, "round_neg_half"};
    vt[6] = '{ns_coef, x7, 2'd0, v3(M8, M8, M8),                     3'b000, "neg_sat_linear"};
    vt[7] = '{ns_coef, x7, 2'd1, v3(Z, Z, Z),                        3'b000, "neg_sat_relu"};
    vt[8] = '{bn_coef, x1, 2'd0, v3(20'hFFFFF, Z, Z),                3'b110, "bias_neg_lsb"};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.act_mode = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    chk("reset in_ready",  64'(bus.in_ready),  64'(1));
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset out_data",  64'(bus.out_data),  64'(0));
    chk("reset out_class", 64'(bus.out_class), 64'(0));
    rst = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      load(vt[v].coef);
      start(vt[v].x, vt[v].mode);
      wait_valid(1'b0, lat);
      chk($sformatf("%s latency", vt[v].name), 64'(lat), 64'(12));
      chk($sformatf("%s data", vt[v].name), 64'(bus.out_data), 64'(vt[v].exp_d));
      chk($sformatf("%s class", vt[v].name), 64'(bus.out_class), 64'(vt[v].exp_c));
      take();
    end

    // Backpressure: result held, new vector refused while DONE.
    load(cl_coef);
    start(x1, 2'd1);
    wait_valid(1'b0, lat);
    chk("bp latency", 64'(lat), 64'(12));
    held = v3(20'h18000, Z, 20'h7FFFF);
    bus.in_valid = 1'b1;
    bus.in_data  = xr;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp data cyc%0d", c),      64'(bus.out_data),  64'(held));
      chk($sformatf("bp in_ready cyc%0d", c),  64'(bus.in_ready),  64'(0));
      chk($sformatf("bp out_valid cyc%0d", c), 64'(bus.out_valid), 64'(1));
    end
    bus.in_valid = 1'b0;
    take();
    chk("bp idle in_ready",  64'(bus.in_ready),  64'(1));
    chk("bp idle out_valid", 64'(bus.out_valid), 64'(0));
    chk("bp data after",     64'(bus.out_data),  64'(held));

    // Write gating: MAC-time write ignored, IDLE write used, out-of-range ignored.
    start(x1, 2'd0);
    wait_valid(1'b1, lat);
    chk("gate mac latency", 64'(lat), 64'(12));
    chk("gate mac write ignored", 64'(bus.out_data), 64'(v3(20'h18000, 20'hF4000, 20'h7FFFF)));
    take();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = ONE;
    tick();
    bus.wr_en = 1'b0;
    start(x1, 2'd0);
    wait_valid(1'b0, lat);
    chk("gate idle write used", 64'(bus.out_data), 64'(v3(20'h28000, 20'hF4000, 20'h7FFFF)));
    take();
    for (int a = 12; a < 16; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = 20'h7FFFF;
      tick();
    end
    bus.wr_en = 1'b0;
    start(x1, 2'd0);
    wait_valid(1'b0, lat);
    chk("gate out of range", 64'(bus.out_data), 64'(v3(20'h28000, 20'hF4000, 20'h7FFFF)));
    chk("gate out of range class", 64'(bus.out_class), 64'(3'b101));
    take();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = Z;
    start(x1, 2'd0);
    wait_valid(1'b0, lat);
    chk("gate accept-cycle write", 64'(bus.out_data), 64'(v3(20'h18000, 20'hF4000, 20'h7FFFF)));
    take();

    // Reset in the 6th MAC cycle aborts and clears coefficients.
    start(x1, 2'd0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst out_data",  64'(bus.out_data),  64'(0));
    chk("rst out_class", 64'(bus.out_class), 64'(0));
    rst = 1'b0;
    start(x1, 2'd0);
    wait_valid(1'b0, lat);
    chk("post-rst latency", 64'(lat), 64'(12));
    chk("post-rst data",    64'(bus.out_data),  64'(0));
    chk("post-rst class",   64'(bus.out_class), 64'(3'b111));
    take();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
